// File: rtl/check_node_message_generator_pkg.sv
// Shared constants and FSM encoding for the check-node message generator.
package check_node_message_generator_pkg;

  localparam int SIGN_BIT     = 31;
  localparam int EXP_MSB      = 30;
  localparam int EXP_LSB      = 23;
  localparam int MAN_MSB      = 22;
  localparam int NUM_CN_EDGES = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_EMIT    = 2'd2,
    ST_DONE    = 2'd3
  } cn_state_e;

endpackage

// File: rtl/check_node_message_generator_normaliser.sv
// Exponent-decrement normalisation of a 31-bit IEEE-754 single magnitude,
// with flush-to-zero on exponent underflow and Inf/NaN passthrough.
module fp_exponent_normaliser
  import check_node_message_generator_pkg::*;
#(
  parameter int unsigned NORM_EXP_DEC = 0
) (
  input  logic [30:0] mag_in,
  output logic [30:0] mag_out
);

  localparam logic [7:0] EXP_DEC = 8'(NORM_EXP_DEC);

  logic [7:0] exp_in;
  assign exp_in = mag_in[EXP_MSB:EXP_LSB];

  always_comb begin
    // NOTE: assign a default before any branching so no path leaves mag_out
    // unassigned; otherwise synthesis infers a latch.
    mag_out = '0;
    if (exp_in == 8'hFF) begin
      mag_out = mag_in;
    end else if (exp_in > EXP_DEC) begin
      mag_out = {exp_in - EXP_DEC, mag_in[MAN_MSB:0]};
    end
  end

endmodule

// File: rtl/check_node_message_generator.sv
// Min-sum check-to-variable message generator: captures min/second_min/pos and
// three V2C messages, forms three C2V messages, and streams them out.
module check_node_message_generator
  import check_node_message_generator_pkg::*;
#(
  parameter int unsigned NORM_EXP_DEC = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] r1,
  input  logic [31:0] r2,
  input  logic [31:0] r3,
  input  logic [31:0] min,
  input  logic [31:0] second_min,
  input  logic [1:0]  pos,
  output logic        busy,
  output logic [31:0] q1,
  output logic [31:0] q2,
  output logic [31:0] q3,
  output logic        msg_valid,
  input  logic        msg_ready,
  output logic [31:0] msg_data,
  output logic [1:0]  msg_edge,
  output logic        done,
  output logic        pos_err
);

  cn_state_e   state;
  logic [2:0]  r_sign;
  logic [30:0] min_mag;
  logic [30:0] smin_mag;
  logic [1:0]  pos_q;
  logic [31:0] q_r    [NUM_CN_EDGES];
  logic [31:0] q_next [NUM_CN_EDGES];
  logic [30:0] mag_sel  [NUM_CN_EDGES];
  logic [30:0] norm_mag [NUM_CN_EDGES];
  logic        s_total;

  // Only the sign bits of r1..r3 and the magnitudes of min/second_min matter.
  logic unused_bits;
  assign unused_bits = ^{r1[30:0], r2[30:0], r3[30:0],
                         min[SIGN_BIT], second_min[SIGN_BIT]};

  assign s_total = ^r_sign;

  // pos==3 matches no edge, so every edge falls back to min.
  for (genvar i = 0; i < NUM_CN_EDGES; i++) begin : g_edge
    assign mag_sel[i] = (pos_q == 2'(i)) ? smin_mag : min_mag;

    fp_exponent_normaliser #(
      .NORM_EXP_DEC(NORM_EXP_DEC)
    ) u_norm (
      .mag_in (mag_sel[i]),
      .mag_out(norm_mag[i])
    );

    assign q_next[i] = {s_total ^ r_sign[i], norm_mag[i]};
  end

  assign q1 = q_r[0];
  assign q2 = q_r[1];
  assign q3 = q_r[2];

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      msg_valid <= 1'b0;
      done      <= 1'b0;
      pos_err   <= 1'b0;
      msg_data  <= '0;
      msg_edge  <= '0;
      r_sign    <= '0;
      min_mag   <= '0;
      smin_mag  <= '0;
      pos_q     <= '0;
      // NOTE: the output array is three visible registers, not a RAM, so it
      // is reset explicitly to keep q1..q3 at zero after reset.
      for (int i = 0; i < NUM_CN_EDGES; i++) q_r[i] <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            r_sign   <= {r3[SIGN_BIT], r2[SIGN_BIT], r1[SIGN_BIT]};
            min_mag  <= min[30:0];
            smin_mag <= second_min[30:0];
            pos_q    <= pos;
            pos_err  <= (pos == 2'd3);
            busy     <= 1'b1;
            state    <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          for (int i = 0; i < NUM_CN_EDGES; i++) q_r[i] <= q_next[i];
          msg_valid <= 1'b1;
          msg_edge  <= 2'd0;
          msg_data  <= q_next[0];
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (msg_ready) begin
            unique case (msg_edge)
              2'd0: begin
                msg_edge <= 2'd1;
                msg_data <= q_r[1];
              end
              2'd1: begin
                msg_edge <= 2'd2;
                msg_data <= q_r[2];
              end
              default: begin
                msg_valid <= 1'b0;
                done      <= 1'b1;
                state     <= ST_DONE;
              end
            endcase
          end
        end
        ST_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_check_node_message_generator.sv
// Scoreboard bench: three instances (NORM_EXP_DEC = 0, 1, 2) share stimulus;
// instance 0's stream is scoreboarded, instances 1 and 2 cover normalisation.
module tb_check_node_message_generator;

  typedef struct {
    logic [1:0]  edge_idx;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] r1 = '0, r2 = '0, r3 = '0, min_in = '0, smin_in = '0;
  logic [1:0]  pos = '0;
  logic        msg_ready = 1'b1;

  logic [2:0]  busy, msg_valid, done, pos_err;
  logic [31:0] q1 [3];
  logic [31:0] q2 [3];
  logic [31:0] q3 [3];
  logic [31:0] msg_data [3];
  logic [1:0]  msg_edge [3];

  exp_t sb_q[$];
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    check_node_message_generator #(
      .NORM_EXP_DEC(g)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .r1        (r1),
      .r2        (r2),
      .r3        (r3),
      .min       (min_in),
      .second_min(smin_in),
      .pos       (pos),
      .busy      (busy[g]),
      .q1        (q1[g]),
      .q2        (q2[g]),
      .q3        (q3[g]),
      .msg_valid (msg_valid[g]),
      .msg_ready (msg_ready),
      .msg_data  (msg_data[g]),
      .msg_edge  (msg_edge[g]),
      .done      (done[g]),
      .pos_err   (pos_err[g])
    );
  end

  task automatic push_expected(input logic [31:0] e0, input logic [31:0] e1,
                               input logic [31:0] e2);
    exp_t e;
    e.edge_idx = 2'd0; e.data = e0; sb_q.push_back(e);
    e.edge_idx = 2'd1; e.data = e1; sb_q.push_back(e);
    e.edge_idx = 2'd2; e.data = e2; sb_q.push_back(e);
  endtask

  // Drives a one-cycle start at a falling edge; returns at the falling edge
  // just after the capture edge.
  task automatic do_start(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [31:0] mn,
                          input logic [31:0] smn, input logic [1:0] p);
    @(negedge clk);
    r1 = a; r2 = b; r3 = c; min_in = mn; smin_in = smn; pos = p;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Consumes the stream of instance 0 against the scoreboard. k counts falling
  // edges after the capture edge; done_k is the k at which done was seen.
  task automatic drain(input int stall_edge, input int stall_cycles,
                       input int inject_k, output int done_k,
                       output int first_k);
    int          stalls_left;
    logic [31:0] held_data;
    exp_t        e;
    bit          finished;
    stalls_left = stall_cycles;
    held_data   = '0;
    done_k      = -1;
    first_k     = -1;
    finished    = 1'b0;
    for (int k = 0; k < 40 && !finished; k++) begin
      if (k == inject_k) begin
        start = 1'b1; r1 = 32'h8000_0001; min_in = 32'h4100_0000;
        smin_in = 32'h4200_0000; pos = 2'd2;
      end else begin
        start = 1'b0;
      end
      if (msg_valid[0] && msg_edge[0] == stall_edge[1:0] && stalls_left > 0) begin
        if (stalls_left < stall_cycles) begin
          n_total++;
          if ({msg_edge[0], msg_data[0]} !== {stall_edge[1:0], held_data})
            $display("FAIL stall_hold k=%0d: got edge %0d data %h, need edge %0d data %h",
                     k, msg_edge[0], msg_data[0], stall_edge[1:0], held_data);
          else n_pass++;
        end
        held_data = msg_data[0];
        msg_ready = 1'b0;
        stalls_left--;
      end else begin
        msg_ready = 1'b1;
      end
      if (msg_valid[0] && msg_ready) begin
        if (first_k < 0) first_k = k;
        n_total++;
        if (sb_q.size() == 0) begin
          $display("FAIL stream_extra k=%0d: got edge %0d data %h, need no message",
                   k, msg_edge[0], msg_data[0]);
        end else begin
          e = sb_q.pop_front();
          if ({msg_edge[0], msg_data[0]} !== {e.edge_idx, e.data})
            $display("FAIL stream k=%0d: got edge %0d data %h, need edge %0d data %h",
                     k, msg_edge[0], msg_data[0], e.edge_idx, e.data);
          else n_pass++;
        end
      end
      if (done[0]) begin
        done_k   = k;
        finished = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    msg_ready = 1'b1;
    if (!finished) begin
      n_total++;
      $display("FAIL drain_timeout: got no done within 40 cycles, need done pulse");
    end
  endtask

  // Called at the falling edge after done: checks the tail of a sequence.
  task automatic check_finished(input string name);
    n_total++;
    if ({busy[0], done[0], msg_valid[0]} !== 3'b000)
      $display("FAIL %s_tail: got busy/done/valid %b, need 000",
               name, {busy[0], done[0], msg_valid[0]});
    else n_pass++;
    n_total++;
    if (sb_q.size() != 0)
      $display("FAIL %s_sb_empty: got %0d pending, need 0", name, sb_q.size());
    else n_pass++;
    sb_q.delete();
  endtask

  task automatic test_reset;
    n_total++;
    if ({busy[0], msg_valid[0], done[0], pos_err[0]} !== 4'b0000)
      $display("FAIL reset_flags: got %b, need 0000",
               {busy[0], msg_valid[0], done[0], pos_err[0]});
    else n_pass++;
    n_total++;
    if ({q1[0], q2[0], q3[0], msg_data[0], msg_edge[0]} !== '0)
      $display("FAIL reset_data: got q %h %h %h data %h edge %0d, need all 0",
               q1[0], q2[0], q3[0], msg_data[0], msg_edge[0]);
    else n_pass++;
  endtask

  task automatic test_basic;
    int done_k, first_k;
    push_expected(32'hBFC0_0000, 32'h3F00_0000, 32'hBF00_0000);
    do_start(32'hBF00_0000, 32'h3FC0_0000, 32'hC000_0000,
             32'h3F00_0000, 32'h3FC0_0000, 2'd0);
    n_total++;
    if (busy[0] !== 1'b1) $display("FAIL basic_busy: got %b, need 1", busy[0]);
    else n_pass++;
    drain(0, 0, -1, done_k, first_k);
    n_total++;
    if (first_k != 1) $display("FAIL basic_valid_latency: got k=%0d, need 1", first_k);
    else n_pass++;
    n_total++;
    if (done_k != 4) $display("FAIL basic_done_latency: got k=%0d, need 4", done_k);
    else n_pass++;
    n_total++;
    if ({q1[0], q2[0], q3[0]} !== {32'hBFC0_0000, 32'h3F00_0000, 32'hBF00_0000})
      $display("FAIL basic_q: got %h %h %h, need bfc00000 3f000000 bf000000",
               q1[0], q2[0], q3[0]);
    else n_pass++;
    n_total++;
    if ({q1[1], q2[1], q3[1]} !== {32'hBF40_0000, 32'h3E80_0000, 32'hBE80_0000})
      $display("FAIL norm1_q: got %h %h %h, need bf400000 3e800000 be800000",
               q1[1], q2[1], q3[1]);
    else n_pass++;
    check_finished("basic");
  endtask

  // Flush and Inf passthrough; also a start in the DONE cycle must be ignored.
  task automatic test_flush_passthrough;
    int done_k, first_k;
    push_expected(32'h0080_0000, 32'h7F80_0000, 32'h0080_0000);
    do_start(32'h0000_0000, 32'h3F80_0000, 32'h0000_0001,
             32'h0080_0000, 32'h7F80_0000, 2'd1);
    drain(0, 0, 4, done_k, first_k);
    n_total++;
    if ({q1[2], q2[2], q3[2]} !== {32'h0000_0000, 32'h7F80_0000, 32'h0000_0000})
      $display("FAIL flush_q: got %h %h %h, need 00000000 7f800000 00000000",
               q1[2], q2[2], q3[2]);
    else n_pass++;
    check_finished("flush");
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy[0], msg_valid[0]} !== 2'b00)
      $display("FAIL start_in_done_ignored: got busy/valid %b, need 00",
               {busy[0], msg_valid[0]});
    else n_pass++;
  endtask

  task automatic test_backpressure;
    int done_k, first_k;
    push_expected(32'hBFC0_0000, 32'h3F00_0000, 32'hBF00_0000);
    do_start(32'hBF00_0000, 32'h3FC0_0000, 32'hC000_0000,
             32'h3F00_0000, 32'h3FC0_0000, 2'd0);
    drain(1, 3, 3, done_k, first_k);
    n_total++;
    if (done_k != 7) $display("FAIL bp_done_latency: got k=%0d, need 7", done_k);
    else n_pass++;
    check_finished("bp");
    repeat (3) @(negedge clk);
    n_total++;
    if ({busy[0], msg_valid[0]} !== 2'b00)
      $display("FAIL bp_start_while_busy_ignored: got busy/valid %b, need 00",
               {busy[0], msg_valid[0]});
    else n_pass++;
  endtask

  task automatic test_pos_err;
    int done_k, first_k;
    push_expected(32'h4000_0000, 32'hC000_0000, 32'hC000_0000);
    do_start(32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
             32'h4000_0000, 32'h4040_0000, 2'd3);
    drain(0, 0, -1, done_k, first_k);
    check_finished("pos3");
    repeat (2) @(negedge clk);
    n_total++;
    if (pos_err[0] !== 1'b1) $display("FAIL pos_err_sticky: got %b, need 1", pos_err[0]);
    else n_pass++;
    push_expected(32'h4040_0000, 32'hC000_0000, 32'hC000_0000);
    do_start(32'h8000_0000, 32'h4000_0000, 32'h0000_0000,
             32'h4000_0000, 32'h4040_0000, 2'd0);
    n_total++;
    if (pos_err[0] !== 1'b0) $display("FAIL pos_err_clear: got %b, need 0", pos_err[0]);
    else n_pass++;
    drain(0, 0, -1, done_k, first_k);
    check_finished("pos0");
  endtask

  task automatic test_reset_mid_emit;
    int done_k, first_k;
    bit saw_done;
    do_start(32'hBF00_0000, 32'h3FC0_0000, 32'hC000_0000,
             32'h3F00_0000, 32'h3FC0_0000, 2'd0);
    @(negedge clk);
    @(negedge clk);
    n_total++;
    if ({msg_valid[0], msg_edge[0]} !== {1'b1, 2'd1})
      $display("FAIL rst_pre_edge: got valid %b edge %0d, need 1 1",
               msg_valid[0], msg_edge[0]);
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({msg_valid[0], busy[0], q1[0], q2[0], q3[0]} !== '0)
      $display("FAIL rst_async_clear: got valid %b busy %b q %h %h %h, need all 0",
               msg_valid[0], busy[0], q1[0], q2[0], q3[0]);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (done[0] || msg_valid[0]) saw_done = 1'b1;
    end
    n_total++;
    if (saw_done) $display("FAIL rst_no_done: got done/valid after reset, need none");
    else n_pass++;
    push_expected(32'hBFC0_0000, 32'h3F00_0000, 32'hBF00_0000);
    do_start(32'hBF00_0000, 32'h3FC0_0000, 32'hC000_0000,
             32'h3F00_0000, 32'h3FC0_0000, 2'd0);
    drain(0, 0, -1, done_k, first_k);
    n_total++;
    if (done_k != 4) $display("FAIL rst_rerun_latency: got k=%0d, need 4", done_k);
    else n_pass++;
    check_finished("rerun");
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_basic();
    test_flush_passthrough();
    test_backpressure();
    test_pos_err();
    test_reset_mid_emit();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/check_node_message_generator.md
Name: check_node_message_generator

Overview:
- Downstream of the check-node min/second-min calculator.
- Takes min, second_min and pos from that stage, plus the three original incoming variable-to-check messages (IEEE-754 single).
- Forms the three outgoing check-to-variable messages using min-sum with optional exponent-decrement normalisation.
- Delivers the messages both as parallel registers and as a serial valid/ready stream to the variable-node update stage.

Parameters:
NORM_EXP_DEC, 0, unsigned amount (0..7) subtracted from the exponent field of every output magnitude; each step scales by 0.5.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle pulse; min/second_min/pos/r1..r3 valid this cycle
r1  input  32  incoming message edge 0 (sign bit used)
r2  input  32  incoming message edge 1 (sign bit used)
r3  input  32  incoming message edge 2 (sign bit used)
min  input  32  absolute minimum magnitude
second_min  input  32  absolute second minimum magnitude
pos  input  2  edge index (0..2) holding the minimum
busy  output  1  high from capture until last message accepted
q1  output  32  outgoing message edge 0 (registered)
q2  output  32  outgoing message edge 1
q3  output  32  outgoing message edge 2
msg_valid  output  1  serial message valid
msg_ready  input  1  downstream accepts when high with msg_valid
msg_data  output  32  serial message payload
msg_edge  output  2  edge index of msg_data
done  output  1  one-cycle pulse after edge 2 accepted
pos_err  output  1  sticky: pos==3 seen at capture; cleared by next valid start

Behaviour:
- Reset (async, rst_n low):
  - state=IDLE
  - busy, msg_valid, done, pos_err = 0
  - q1..q3, msg_data = 0
  - msg_edge = 0
- States: IDLE, COMPUTE, EMIT, DONE.
- IDLE: start=1 captures all inputs into holding registers and moves to COMPUTE. start is ignored in any other state; no queueing.
- COMPUTE (exactly 1 cycle):
  - s_i = sign bit of r_i.
  - S = s_0 ^ s_1 ^ s_2.
  - mag_i = (i==pos) ? second_min[30:0] : min[30:0]. Input sign bits of min/second_min are ignored.
  - Normalisation: e = mag_i[30:23].
    - If e > NORM_EXP_DEC: e_out = e - NORM_EXP_DEC, mantissa kept.
    - Else: the result is flushed to zero (exponent and mantissa = 0).
    - Inf/NaN (e==255) pass through unmodified.
  - q_i = {S ^ s_i, normalised mag_i}, loaded into q1..q3 at the end of COMPUTE.
  - pos==3: all edges use min, and pos_err is set.
  - Move to EMIT with msg_edge=0, msg_valid=1, msg_data=q1.
- EMIT:
  - msg_data and msg_edge hold stable while msg_valid && !msg_ready.
  - On handshake (msg_valid && msg_ready): msg_edge advances 0→1→2 with msg_data = q1/q2/q3.
  - A handshake on edge 2 drops msg_valid next cycle and moves to DONE.
  - msg_valid stays continuously high between edges; no bubble is required.
- DONE (1 cycle): done=1, busy=0 next cycle, return to IDLE. A start in the DONE cycle is ignored.
- Latency: start at cycle T → q1..q3 valid and msg_valid high at T+2. With msg_ready tied high, done pulses at T+5.
- busy is high in COMPUTE, EMIT and DONE.
- q1..q3 hold their values until the next COMPUTE.
- Reset mid-operation clears the state immediately. No partial message is delivered afterwards, and done is not asserted.
- Zero inputs: a sign bit of 1 on -0.0 counts as negative. Equal min and second_min are legal.

Decomposition:
- Shared package holds:
  - FP field constants: SIGN_BIT=31, EXP_MSB=30, EXP_LSB=23, MAN_MSB=22.
  - Edge count constant NUM_CN_EDGES=3.
  - FSM state encoding.
- One sub-module, fp_exponent_normaliser: combinational; applies NORM_EXP_DEC, flush-to-zero and Inf/NaN passthrough to a 31-bit magnitude. It is instantiated three times.

Test Plan:
- Basic min-sum, NORM_EXP_DEC=0, msg_ready=1:
  - Stimulus: r1=0xBF000000, r2=0x3FC00000, r3=0xC0000000, min=0x3F000000, second_min=0x3FC00000, pos=0.
  - Expected: q1=0xBFC00000, q2=0x3F000000, q3=0xBF000000.
  - Stream emits edges 0,1,2 in order; done pulses at start+5.
- Normalisation, NORM_EXP_DEC=1, same stimulus:
  - Expected: q1=0xBF400000, q2=0x3E800000, q3=0xBE800000.
- Flush and passthrough, NORM_EXP_DEC=2:
  - Stimulus: min=0x00800000, second_min=0x7F800000, pos=1, all r positive.
  - Expected: q1=0x00000000, q2=0x7F800000, q3=0x00000000.
- Backpressure:
  - Stimulus: msg_ready low for 3 cycles on edge 1.
  - Expected: msg_data=q2 and msg_edge=1 stay stable; no skip or duplicate; done only after edge 2 is accepted; a start while busy is ignored.
- pos=3:
  - Expected: all three outputs use min; pos_err=1 and remains set until the next start with valid pos.
- Reset mid-EMIT:
  - Stimulus: rst_n low after the edge 0 handshake.
  - Expected: msg_valid, busy and q1..q3 go to 0 asynchronously; no done pulse; a subsequent start runs a full, correct sequence.
